flag_shadow_save: RTL and testbench
===================================

FLAG_SHADOW_SAVE -- requirements
Module: flag_shadow_save

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have ports C_IN and Z_IN, input, 1 bit each: ALU carry and zero results.
REQ-004 SHALL have ports FLG_C_LD and FLG_Z_LD, input, 1 bit each: load enables for the C and Z flags.
REQ-005 SHALL have ports FLG_C_SET and FLG_C_CLR, input, 1 bit each: SEC and CLC controls.
REQ-006 SHALL have port FLG_SHAD_LD, input, 1 bit: save the current C/Z into the shadow at interrupt entry.
REQ-007 SHALL have port FLG_LD_SEL, input, 1 bit: when high, flag loads take the shadow value instead of C_IN/Z_IN (RETID/RETIE restore).
REQ-008 SHALL have ports C_FLAG and Z_FLAG, output, 1 bit each: the architectural flags.
REQ-009 SHALL have ports SHAD_C and SHAD_Z, output, 1 bit each: the shadow entry currently on top.
REQ-010 SHALL have port SHAD_VALID, output, 1 bit: at least one saved entry is held.
REQ-011 SHALL have ports SHAD_OVF and SHAD_UNF, output, 1 bit each: sticky save-overflow and restore-underflow errors.

Function
REQ-012 SHALL give C the priority FLG_C_CLR > FLG_C_SET > FLG_C_LD > hold; Z SHALL be FLG_Z_LD > hold.
REQ-013 SHALL make the load source SHAD_C/SHAD_Z when FLG_LD_SEL=1 and C_IN/Z_IN otherwise; a restore is FLG_LD_SEL=1 with FLG_C_LD or FLG_Z_LD high.
REQ-014 SHALL make a save capture the C_FLAG/Z_FLAG values from before the same-edge update.
REQ-015 SHALL make flag outputs registered, visible one cycle after the load edge, with no combinational path from inputs to outputs.
REQ-016 SHALL implement a shadow state machine with states EMPTY and HELD: save moves to HELD; restore moves to EMPTY.
REQ-017 SHALL, on a save while HELD, overwrite the shadow and set SHAD_OVF.
REQ-018 SHALL, on a restore while EMPTY, load the stored (stale) shadow value, set SHAD_UNF and remain EMPTY.
REQ-019 SHALL, on a save and restore in the same cycle, restore from the old top and then write the new entry, ending in HELD with no error flag set.
REQ-020 SHALL keep SHAD_OVF and SHAD_UNF set until RST.

Reset
REQ-021 SHALL, while RST=1 at a rising edge, clear C_FLAG, Z_FLAG, every shadow entry, SHAD_VALID, SHAD_OVF and SHAD_UNF, and enter EMPTY, overriding all other inputs.
REQ-022 SHALL make RST asserted mid-save or mid-restore discard the operation completely.

Configuration
REQ-023 SHALL, with FLAG_STACK_EN defined, replace the single shadow with a 4-deep LIFO and a 3-bit count 0..4; save pushes and restore pops.
REQ-024 SHALL, with FLAG_STACK_EN defined, drop a push at count 4 and set SHAD_OVF, leaving the contents unchanged.
REQ-025 SHALL, with FLAG_STACK_EN defined, make a pop at count 0 load 0/0 and set SHAD_UNF.
REQ-026 SHALL, with FLAG_STACK_EN defined, make a simultaneous push and pop replace the top entry and leave the count unchanged.
REQ-027 SHALL, with FLAG_STACK_EN defined, drive SHAD_VALID as count!=0.
REQ-028 SHALL, with FLAG_STACK_EN undefined, behave exactly as REQ-016..REQ-019, at identical port width.

Structure
REQ-029 SHALL place the shadow state enum (EMPTY, HELD), the constant FLAG_STACK_DEPTH=4 and the count width in shared package flag_pkg.
REQ-030 SHALL isolate shadow storage in one sub-module, flag_shadow_stack (push, pop, top, count, ovf, unf), with the single-level and LIFO variants selected inside it.

Verification
REQ-031 SHALL check: RST=1 with all controls high -> next cycle all outputs 0.
REQ-032 SHALL check: C=1,Z=0 then FLG_SHAD_LD, next cycle C_IN=0,Z_IN=1 loaded, then FLG_LD_SEL=1 with both loads -> C_FLAG=1, Z_FLAG=0, SHAD_VALID=0.
REQ-033 SHALL check: FLG_C_SET and FLG_C_CLR together with FLG_C_LD, C_IN=1 -> C_FLAG=0.
REQ-034 SHALL check: restore with nothing saved -> SHAD_UNF=1 and stays 1 through 10 idle cycles.
REQ-035 SHALL check: save and restore in the same cycle, old shadow C=1, current C=0 -> C_FLAG=1, SHAD_C=0, SHAD_VALID=1, no errors.
REQ-036 SHALL check, under FLAG_STACK_EN: 5 saves of distinct C/Z values -> SHAD_OVF=1 after the 5th; then 4 restores return entries 4,3,2,1 in order and SHAD_VALID=0.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared types and constants for the C/Z flag register and its shadow storage.
package flag_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } shad_state_e;

    localparam int unsigned FLAG_STACK_DEPTH = 4;
    localparam int unsigned FLAG_CNT_W       = 3;

endpackage

// File: rtl/flag_shadow_stack.sv
// Shadow storage for saved C/Z pairs: single entry by default, 4-deep LIFO
// when FLAG_STACK_EN is defined. Top entry and all status are registered.
module flag_shadow_stack
    import flag_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  push_c_i,
    input  logic                  push_z_i,
    output logic                  top_c_o,
    output logic                  top_z_o,
    output logic [FLAG_CNT_W-1:0] count_o,
    output logic                  ovf_o,
    output logic                  unf_o
);

`ifdef FLAG_STACK_EN

    localparam logic [FLAG_CNT_W-1:0] FULL = FLAG_CNT_W'(FLAG_STACK_DEPTH);

    logic [1:0]            mem_q [FLAG_STACK_DEPTH];
    logic [FLAG_CNT_W-1:0] cnt_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic [1:0]            top_idx;

    assign top_idx = cnt_q[1:0] - 2'd1;

    // Push+pop at count 0 behaves as a plain push so the new entry is kept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < FLAG_STACK_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (push_i && pop_i) begin
            if (cnt_q == '0) begin
                mem_q[0] <= {push_c_i, push_z_i};
                cnt_q    <= FLAG_CNT_W'(1);
            end else begin
                mem_q[top_idx] <= {push_c_i, push_z_i};
            end
        end else if (push_i) begin
            if (cnt_q == FULL) begin
                ovf_q <= 1'b1;
            end else begin
                mem_q[cnt_q[1:0]] <= {push_c_i, push_z_i};
                cnt_q             <= cnt_q + FLAG_CNT_W'(1);
            end
        end else if (pop_i) begin
            if (cnt_q == '0) begin
                unf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - FLAG_CNT_W'(1);
            end
        end
    end

    assign top_c_o = (cnt_q != '0) ? mem_q[top_idx][1] : 1'b0;
    assign top_z_o = (cnt_q != '0) ? mem_q[top_idx][0] : 1'b0;
    assign count_o = cnt_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

`else

    shad_state_e state_q, state_d;
    logic [1:0]  shad_q, shad_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            shad_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shad_q  <= shad_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // A restore leaves the stored pair in place, so a later underflow reads it stale.
    always_comb begin
        state_d = state_q;
        shad_d  = shad_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (state_q)
            EMPTY: begin
                if (push_i) begin
                    state_d = HELD;
                    shad_d  = {push_c_i, push_z_i};
                end else if (pop_i) begin
                    unf_d = 1'b1;
                end
            end
            HELD: begin
                if (push_i) begin
                    shad_d = {push_c_i, push_z_i};
                    if (!pop_i) begin
                        ovf_d = 1'b1;
                    end
                end else if (pop_i) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign top_c_o = shad_q[1];
    assign top_z_o = shad_q[0];
    assign count_o = {{(FLAG_CNT_W-1){1'b0}}, state_q == HELD};
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

`endif

endmodule

// File: rtl/flag_shadow_save.sv
// Architectural C/Z flags with shadow save/restore for interrupt entry/exit.
// Define FLAG_STACK_EN to use a 4-deep shadow LIFO instead of a single entry.
module flag_shadow_save
    import flag_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic C_IN,
    input  logic Z_IN,
    input  logic FLG_C_LD,
    input  logic FLG_Z_LD,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic FLG_SHAD_LD,
    input  logic FLG_LD_SEL,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic SHAD_C,
    output logic SHAD_Z,
    output logic SHAD_VALID,
    output logic SHAD_OVF,
    output logic SHAD_UNF
);

    logic                  c_q, c_d;
    logic                  z_q, z_d;
    logic                  top_c, top_z;
    logic [FLAG_CNT_W-1:0] shad_cnt;
    logic                  restore;
    logic                  src_c, src_z;

    assign restore = FLG_LD_SEL & (FLG_C_LD | FLG_Z_LD);
    assign src_c   = FLG_LD_SEL ? top_c : C_IN;
    assign src_z   = FLG_LD_SEL ? top_z : Z_IN;

    always_comb begin
        c_d = c_q;
        z_d = z_q;
        if (FLG_C_CLR) begin
            c_d = 1'b0;
        end else if (FLG_C_SET) begin
            c_d = 1'b1;
        end else if (FLG_C_LD) begin
            c_d = src_c;
        end
        if (FLG_Z_LD) begin
            z_d = src_z;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            c_q <= c_d;
            z_q <= z_d;
        end
    end

    flag_shadow_stack u_stack (
        .clk_i    (CLK),
        .rst_i    (RST),
        .push_i   (FLG_SHAD_LD),
        .pop_i    (restore),
        .push_c_i (c_q),
        .push_z_i (z_q),
        .top_c_o  (top_c),
        .top_z_o  (top_z),
        .count_o  (shad_cnt),
        .ovf_o    (SHAD_OVF),
        .unf_o    (SHAD_UNF)
    );

    assign C_FLAG     = c_q;
    assign Z_FLAG     = z_q;
    assign SHAD_C     = top_c;
    assign SHAD_Z     = top_z;
    assign SHAD_VALID = (shad_cnt != '0);

endmodule

// File: tb/tb_flag_shadow_save.sv
// Bench for flag_shadow_save: directed vector table, hand sequences and a
// randomized run against a queue-based reference model.
module tb_flag_shadow_save;

    logic CLK = 1'b0;
    logic RST, C_IN, Z_IN, FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR;
    logic FLG_SHAD_LD, FLG_LD_SEL;
    logic C_FLAG, Z_FLAG, SHAD_C, SHAD_Z, SHAD_VALID, SHAD_OVF, SHAD_UNF;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    flag_shadow_save dut (
        .CLK         (CLK),
        .RST         (RST),
        .C_IN        (C_IN),
        .Z_IN        (Z_IN),
        .FLG_C_LD    (FLG_C_LD),
        .FLG_Z_LD    (FLG_Z_LD),
        .FLG_C_SET   (FLG_C_SET),
        .FLG_C_CLR   (FLG_C_CLR),
        .FLG_SHAD_LD (FLG_SHAD_LD),
        .FLG_LD_SEL  (FLG_LD_SEL),
        .C_FLAG      (C_FLAG),
        .Z_FLAG      (Z_FLAG),
        .SHAD_C      (SHAD_C),
        .SHAD_Z      (SHAD_Z),
        .SHAD_VALID  (SHAD_VALID),
        .SHAD_OVF    (SHAD_OVF),
        .SHAD_UNF    (SHAD_UNF)
    );

    // Input bundle order: rst, c_in, z_in, c_ld, z_ld, c_set, c_clr, shad_ld, ld_sel
    typedef struct packed {
        logic rst, cin, zin, cld, zld, cset, cclr, shld, sel;
    } in_t;

    // Expected output order: C, Z, SHAD_C, SHAD_Z, SHAD_VALID, SHAD_OVF, SHAD_UNF
    typedef struct {
        in_t        i;
        logic [6:0] e;
    } vec_t;

    // Reference model: flags plus a list of saved pairs (newest at the back).
    logic       m_c = 1'b0, m_z = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
    logic [1:0] m_saved [$];
    logic [1:0] m_stale = 2'b00;

    function automatic logic [1:0] model_top();
`ifdef FLAG_STACK_EN
        return (m_saved.size() != 0) ? m_saved[$] : 2'b00;
`else
        return m_stale;
`endif
    endfunction

    function automatic logic [6:0] model_out();
        logic [1:0] t;
        t = model_top();
        return {m_c, m_z, t, m_saved.size() != 0, m_ovf, m_unf};
    endfunction

    task automatic model_step(input in_t x);
        logic [1:0] t, old;
        logic       rs, sv, sc, sz;
        if (x.rst) begin
            m_c = 0; m_z = 0; m_ovf = 0; m_unf = 0;
            m_saved.delete();
            m_stale = 2'b00;
            return;
        end
        t   = model_top();
        old = {m_c, m_z};
        rs  = x.sel && (x.cld || x.zld);
        sv  = x.shld;
        sc  = x.sel ? t[1] : x.cin;
        sz  = x.sel ? t[0] : x.zin;
        if (x.cclr) m_c = 0;
        else if (x.cset) m_c = 1;
        else if (x.cld) m_c = sc;
        if (x.zld) m_z = sz;
`ifdef FLAG_STACK_EN
        if (sv && rs) begin
            if (m_saved.size() == 0) m_saved.push_back(old);
            else m_saved[m_saved.size()-1] = old;
        end else if (sv) begin
            if (m_saved.size() == 4) m_ovf = 1;
            else m_saved.push_back(old);
        end else if (rs) begin
            if (m_saved.size() == 0) m_unf = 1;
            else void'(m_saved.pop_back());
        end
`else
        if (sv) begin
            if (m_saved.size() != 0 && !rs) m_ovf = 1;
            m_saved.delete();
            m_saved.push_back(old);
            m_stale = old;
        end else if (rs) begin
            if (m_saved.size() == 0) m_unf = 1;
            m_saved.delete();
        end
`endif
    endtask

    task automatic apply(input in_t x);
        @(negedge CLK);
        {RST, C_IN, Z_IN, FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR, FLG_SHAD_LD, FLG_LD_SEL} = x;
        @(posedge CLK);
        model_step(x);
        #1;
    endtask

    function automatic logic [6:0] dut_out();
        return {C_FLAG, Z_FLAG, SHAD_C, SHAD_Z, SHAD_VALID, SHAD_OVF, SHAD_UNF};
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (C Z SC SZ V OVF UNF)", name, got, exp);
        end
    endtask

    localparam in_t IDLE = '0;
    localparam in_t RSTV = 9'b1_0_0_0_0_0_0_0_0;

    vec_t vecs [$];

    initial begin
        in_t x;
        logic [1:0] ent [5];

        {RST, C_IN, Z_IN, FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR, FLG_SHAD_LD, FLG_LD_SEL} = '0;

`ifndef FLAG_STACK_EN
        vecs.push_back('{9'b1_1_1_1_1_1_1_1_1, 7'b00_00_000}); // reset beats everything
        vecs.push_back('{9'b0_1_0_1_1_0_0_0_0, 7'b10_00_000}); // C=1 Z=0
        vecs.push_back('{9'b0_0_0_0_0_0_0_1_0, 7'b10_10_100}); // save
        vecs.push_back('{9'b0_0_1_1_1_0_0_0_0, 7'b01_10_100}); // load C=0 Z=1
        vecs.push_back('{9'b0_0_1_1_1_0_0_0_1, 7'b10_10_000}); // restore
        vecs.push_back('{9'b0_1_0_1_0_1_1_0_0, 7'b00_10_000}); // clr > set > ld
        vecs.push_back('{9'b0_0_0_0_0_1_0_0_0, 7'b10_10_000}); // set
        vecs.push_back('{9'b0_0_0_0_0_0_1_0_0, 7'b00_10_000}); // clr
        vecs.push_back('{9'b0_0_1_0_1_0_0_0_0, 7'b01_10_000}); // Z load
        vecs.push_back('{9'b0_0_0_0_0_1_0_0_0, 7'b11_10_000}); // C=1
        vecs.push_back('{9'b0_0_0_0_0_0_0_1_0, 7'b11_11_100}); // save {1,1}
        vecs.push_back('{9'b0_0_0_0_0_0_1_0_0, 7'b01_11_100}); // C=0
        vecs.push_back('{9'b0_0_0_1_1_0_0_1_1, 7'b11_01_100}); // save+restore
        vecs.push_back('{9'b0_0_0_0_0_0_0_1_0, 7'b11_11_110}); // save while held
        vecs.push_back('{9'b0_0_0_1_0_0_0_0_1, 7'b11_11_010}); // restore C
        vecs.push_back('{9'b0_0_0_0_0_0_1_0_0, 7'b01_11_010}); // C=0
        vecs.push_back('{9'b0_0_0_1_0_0_0_0_1, 7'b11_11_011}); // restore empty: stale
        vecs.push_back('{9'b0_0_0_0_0_0_0_0_0, 7'b11_11_011}); // sticky
        vecs.push_back('{9'b1_0_0_0_0_0_0_0_0, 7'b00_00_000}); // reset clears errors
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].i);
            check($sformatf("vec%0d", i), dut_out(), vecs[i].e);
        end
`endif

        // Underflow from a fresh reset stays sticky while idle.
        apply(RSTV);
        check("rst_state", dut_out(), 7'b0);
        apply(9'b0_1_1_1_1_0_0_0_1);
        check("unf_set", {6'b0, SHAD_UNF}, 7'd1);
        for (int i = 0; i < 10; i++) begin
            apply(IDLE);
            check($sformatf("unf_sticky%0d", i), {6'b0, SHAD_UNF}, 7'd1);
        end

`ifdef FLAG_STACK_EN
        ent = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11};
        apply(RSTV);
        for (int i = 0; i < 5; i++) begin
            x = IDLE; x.cld = 1; x.zld = 1; x.cin = ent[i][1]; x.zin = ent[i][0];
            apply(x);
            x = IDLE; x.shld = 1;
            apply(x);
        end
        check("stk_ovf", {5'b0, SHAD_VALID, SHAD_OVF}, 7'b11);
        check("stk_top", {5'b0, SHAD_C, SHAD_Z}, {5'b0, ent[3]});
        for (int i = 3; i >= 0; i--) begin
            x = IDLE; x.sel = 1; x.cld = 1; x.zld = 1;
            apply(x);
            check($sformatf("stk_pop%0d", i), {5'b0, C_FLAG, Z_FLAG}, {5'b0, ent[i]});
        end
        check("stk_empty", {5'b0, SHAD_VALID, SHAD_UNF}, 7'b0);
`endif

        apply(RSTV);
        for (int n = 0; n < 500; n++) begin
            x = in_t'($urandom_range(0, 511));
            x.rst = ($urandom_range(0, 40) == 0);
            x.sel = ($urandom_range(0, 2) == 0);
            x.cclr = x.cclr & ($urandom_range(0, 1) == 0);
            x.cset = x.cset & ($urandom_range(0, 1) == 0);
            x.shld = ($urandom_range(0, 3) == 0);
            apply(x);
            check($sformatf("rand%0d", n), dut_out(), model_out());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
